byte_unstriping_param: RTL and testbench

BYTE_UNSTRIPING_PARAM -- requirements
Module: byte_unstriping_param

---
 rtl/byte_unstriping_param.sv | 196 +++++++++++++++++++
 tb/tb_byte_unstriping_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_unstriping_param.sv
// rtl/byte_unstriping_param.sv - lane word to byte serializer with K-symbol packet framing checker
module byte_unstriping_param #(
  parameter int         LANES = 4,
  parameter logic [7:0] COM   = 8'hBC,
  parameter logic [7:0] SKP   = 8'h1C,
  parameter logic [7:0] PAD   = 8'hF7,
  parameter logic [7:0] IDL   = 8'h7C,
  parameter logic [7:0] FTS   = 8'h3C,
  parameter logic [7:0] STP   = 8'hFB,
  parameter logic [7:0] SDP   = 8'h5C,
  parameter logic [7:0] END   = 8'hFD,
  parameter logic [7:0] EDB   = 8'hFE
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [1:0]         width_sel,
  input  logic [8*LANES-1:0] lane_data,
  input  logic [LANES-1:0]   lane_k,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_k,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic               out_nullify,
  output logic               err_framing,
  input  logic               clear_err
);

  localparam logic [3:0] LANES_N = 4'(LANES);

  typedef enum logic {IDLE, IN_PKT} state_t;

  typedef struct packed {
    logic   emit;
    logic   sop;
    logic   eop;
    logic   nul;
    logic   err;
    state_t nxt;
  } cls_t;

  // Decide the fate of one slot given the framing state it will be consumed in.
  function automatic cls_t classify(input logic [7:0] b, input logic k, input state_t s);
    cls_t c;
    c = '0;
    c.nxt = s;
    if (!k) begin
      if (s == IN_PKT) c.emit = 1'b1;
      else             c.err  = 1'b1;
    end else if (b == COM || b == SKP || b == PAD || b == IDL || b == FTS) begin
      c.emit = 1'b0;
    end else if (b == STP || b == SDP) begin
      c.emit = 1'b1;
      c.sop  = 1'b1;
      c.err  = (s == IN_PKT);
      c.nxt  = IN_PKT;
    end else if (b == END || b == EDB) begin
      if (s == IN_PKT) begin
        c.emit = 1'b1;
        c.eop  = 1'b1;
        c.nul  = (b == EDB);
        c.nxt  = IDLE;
      end else begin
        c.err = 1'b1;
      end
    end else begin
      c.err = 1'b1;
    end
    return c;
  endfunction

  logic [8*LANES-1:0] mem_data [2];
  logic [LANES-1:0]   mem_k [2];
  logic               wr_ptr, rd_ptr, rdy_en;
  logic [1:0]         count;
  logic [3:0]         n_reg, slot_idx;
  logic               slot_active, slot_err;
  state_t             state, slot_nxt;

  logic [3:0]         width_n, n_eff, src_idx;
  logic               idle_empty, accept, consume, last_slot, free, load, src_kbit;
  logic [8*LANES-1:0] src_data;
  logic [LANES-1:0]   src_k;
  logic [7:0]         src_byte;
  state_t             state_after;
  cls_t               cls;

  always_comb begin
    width_n = 4'd1 << width_sel;
    if (width_n > LANES_N) width_n = LANES_N;
  end

  assign idle_empty  = (count == 2'd0) && !slot_active;
  assign n_eff       = idle_empty ? width_n : n_reg;
  assign in_ready    = rdy_en && (count != 2'd2);
  assign accept      = in_valid && in_ready;
  assign consume     = slot_active && (!out_valid || out_ready);
  assign last_slot   = (slot_idx == n_eff - 4'd1);
  assign free        = consume && last_slot;
  assign state_after = consume ? slot_nxt : state;

  // Next slot source: same head entry, the second buffered entry, or the word being accepted now.
  always_comb begin
    load     = 1'b0;
    src_data = lane_data;
    src_k    = lane_k;
    src_idx  = 4'd0;
    if (consume && !last_slot) begin
      load     = 1'b1;
      src_data = mem_data[rd_ptr];
      src_k    = mem_k[rd_ptr];
      src_idx  = slot_idx + 4'd1;
    end else if (consume && count == 2'd2) begin
      load     = 1'b1;
      src_data = mem_data[~rd_ptr];
      src_k    = mem_k[~rd_ptr];
    end else if ((consume || !slot_active) && accept) begin
      load = 1'b1;
    end
  end

  always_comb begin
    src_byte = src_data[7:0];
    src_kbit = src_k[0];
    for (int i = 1; i < LANES; i++) begin
      if (src_idx == 4'(i)) begin
        src_byte = src_data[8*i +: 8];
        src_kbit = src_k[i];
      end
    end
  end

  assign cls = classify(src_byte, src_kbit, state_after);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr] <= lane_data;
      mem_k[wr_ptr]    <= lane_k;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rdy_en      <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      n_reg       <= LANES_N;
      slot_idx    <= 4'd0;
      slot_active <= 1'b0;
      slot_err    <= 1'b0;
      slot_nxt    <= IDLE;
      state       <= IDLE;
      err_framing <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_k       <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_nullify <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      n_reg  <= n_eff;
      if (accept) wr_ptr <= ~wr_ptr;
      if (free)   rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, free};
      if (consume) state <= slot_nxt;
      err_framing <= (err_framing && !clear_err) || (consume && slot_err);
      if (load) begin
        slot_active <= 1'b1;
        slot_idx    <= src_idx;
        slot_err    <= cls.err;
        slot_nxt    <= cls.nxt;
        out_valid   <= cls.emit;
        out_data    <= cls.emit ? src_byte : 8'h00;
        out_k       <= cls.emit && src_kbit;
        out_sop     <= cls.sop;
        out_eop     <= cls.eop;
        out_nullify <= cls.nul;
      end else if (consume) begin
        slot_active <= 1'b0;
        slot_err    <= 1'b0;
        out_valid   <= 1'b0;
        out_data    <= 8'h00;
        out_k       <= 1'b0;
        out_sop     <= 1'b0;
        out_eop     <= 1'b0;
        out_nullify <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_unstriping_param.sv
// tb/tb_byte_unstriping_param.sv - directed scoreboard bench for byte_unstriping_param
module tb_byte_unstriping_param;

  logic        clk, reset_L, in_valid, in_ready, out_k, out_valid, out_ready;
  logic        out_sop, out_eop, out_nullify, err_framing, clear_err;
  logic [1:0]  width_sel;
  logic [63:0] lane_data;
  logic [7:0]  lane_k, out_data;

  int total = 0;
  int bad = 0;
  logic [12:0] q[$];
  logic [12:0] exp_e, cur;
  logic        prev_stall = 1'b0;
  logic [12:0] prev_word;
  time         acc_time, t0;

  byte_unstriping_param #(.LANES(8)) dut (
    .clk(clk), .reset_L(reset_L), .width_sel(width_sel),
    .lane_data(lane_data), .lane_k(lane_k),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_k(out_k), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_nullify(out_nullify),
    .err_framing(err_framing), .clear_err(clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic k, input logic s, input logic e, input logic n);
    q.push_back({1'b1, d, k, s, e, n});
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k);
    logic ok;
    ok = 1'b0;
    lane_data = d;
    lane_k    = k;
    in_valid  = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    acc_time = $time;
    #1;
    in_valid  = 1'b0;
    lane_data = '0;
    lane_k    = '0;
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_L) begin
      prev_stall = 1'b0;
    end else begin
      cur = {out_valid, out_data, out_k, out_sop, out_eop, out_nullify};
      if (prev_stall) chk("hold", cur, prev_word);
      if (out_valid && out_ready) begin
        exp_e = (q.size() > 0) ? q.pop_front() : 13'd0;
        chk("sb_byte", {1'b1, out_data, out_k, out_sop, out_eop, out_nullify}, exp_e);
      end else if (!out_valid) begin
        chk("strobes_idle", {out_sop, out_eop, out_nullify}, 3'b000);
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = cur;
    end
  end

  initial begin
    reset_L = 1'b0; width_sel = 2'd2; lane_data = '0; lane_k = '0;
    in_valid = 1'b0; out_ready = 1'b1; clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_k", out_k, 0);
    chk("rst_strobes", {out_sop, out_eop, out_nullify}, 3'b000);
    chk("rst_err", err_framing, 0);
    reset_L = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_rise", in_ready, 1);

    // x4 STP FF FF END, upper lanes carry junk
    width_sel = 2'd2;
    push(8'hFB, 1, 1, 0, 0); push(8'hFF, 0, 0, 0, 0);
    push(8'hFF, 0, 0, 0, 0); push(8'hFD, 1, 0, 1, 0);
    send(64'h99999999_FDFFFFFB, 8'h09);
    chk("x4_lat_valid", out_valid, 1);
    chk("x4_lat_data", out_data, 8'hFB);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("x4_consec", out_valid, 1);
    end
    @(posedge clk); #1;
    chk("x4_after", out_valid, 0);
    drain();
    chk("x4_err", err_framing, 0);

    // x1 STP 5A A5 EDB, one word per accept, back to back
    width_sel = 2'd0;
    push(8'hFB, 1, 1, 0, 0); push(8'h5A, 0, 0, 0, 0);
    push(8'hA5, 0, 0, 0, 0); push(8'hFE, 1, 0, 1, 1);
    send(64'h99999999_999999FB, 8'h01);
    t0 = acc_time;
    send(64'h99999999_9999995A, 8'h00);
    send(64'h99999999_999999A5, 8'h00);
    send(64'h99999999_999999FE, 8'h01);
    chk("x1_back_to_back", 32'((acc_time - t0) / 10), 3);
    drain();
    chk("x1_err", err_framing, 0);

    // x4 SDP 11 22 33 with a 3-cycle stall on 11 and a second word filling the FIFO
    width_sel = 2'd2;
    push(8'h5C, 1, 1, 0, 0); push(8'h11, 0, 0, 0, 0);
    push(8'h22, 0, 0, 0, 0); push(8'h33, 0, 0, 0, 0);
    send(64'h99999999_3322115C, 8'h01);
    @(posedge clk); #1;
    chk("stall_at_11", out_data, 8'h11);
    out_ready = 1'b0;
    push(8'h44, 0, 0, 0, 0); push(8'h55, 0, 0, 0, 0);
    push(8'h66, 0, 0, 0, 0); push(8'hFD, 1, 0, 1, 0);
    send(64'h99999999_FD665544, 8'h08);
    chk("full_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_data", out_data, 8'h11);
    chk("stall_valid", out_valid, 1);
    out_ready = 1'b1;
    drain();
    chk("stall_err", err_framing, 0);

    // x2 SKP IDL then 77 END in IDLE: nothing emitted, 77 raises the error
    width_sel = 2'd1;
    send(64'h99999999_99997C1C, 8'h03);
    repeat (3) @(posedge clk);
    #1;
    chk("skp_idl_noerr", err_framing, 0);
    send(64'h99999999_9999FD77, 8'h02);
    chk("err_before_77", err_framing, 0);
    @(posedge clk); #1;
    chk("err_after_77", err_framing, 1);
    repeat (3) @(posedge clk);
    #1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    chk("clear_err", err_framing, 0);

    // Clear held across an error-setting consume: the set must win
    send(64'h99999999_9999F733, 8'h02);
    clear_err = 1'b1;
    @(posedge clk); #1;
    chk("set_wins", err_framing, 1);
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    chk("clear_again", err_framing, 0);

    // x8 then width_sel=x4 mid-stream: second word still x8, third word x4
    width_sel = 2'd3;
    push(8'hFB, 1, 1, 0, 0);
    for (int i = 1; i < 7; i++) push(8'(i), 0, 0, 0, 0);
    push(8'hFD, 1, 0, 1, 0);
    send(64'hFD060504_030201FB, 8'h81);
    width_sel = 2'd2;
    push(8'hFB, 1, 1, 0, 0);
    for (int i = 1; i < 7; i++) push(8'(8'hA0 + i), 0, 0, 0, 0);
    push(8'hFD, 1, 0, 1, 0);
    send(64'hFDA6A5A4_A3A2A1FB, 8'h81);
    drain();
    push(8'hFB, 1, 1, 0, 0); push(8'hB1, 0, 0, 0, 0);
    push(8'hB2, 0, 0, 0, 0); push(8'hFD, 1, 0, 1, 0);
    send(64'h99999999_FDB2B1FB, 8'h09);
    drain();
    chk("width_err", err_framing, 0);

    // Reset inside a packet discards the rest and returns the FSM to IDLE
    width_sel = 2'd2;
    push(8'hFB, 1, 1, 0, 0);
    send(64'h99999999_302010FB, 8'h01);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset_L = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_strobes", {out_k, out_sop, out_eop, out_nullify}, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
    out_ready = 1'b1;
    width_sel = 2'd0;
    send(64'h99999999_99999977, 8'h00);
    @(posedge clk); #1;
    chk("post_rst_77_err", err_framing, 1);
    drain();
    chk("sb_empty_end", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
